// File: rtl/psram_system.sv
// psram_system: PSRAM bring-up tester (pattern write, readback, LED status).
// Optional byte-lane check: define PSRAM_BYTE_LANE_TEST_EN.
module psram_system #(
  parameter int clk_freq    = 80000000,
  parameter int init_cycles = 8000,
  parameter int t_acc       = 6,
  parameter int n_words     = 64
) (
  input  logic        clk,
  input  logic        btns,
  output logic [7:0]  leds,
  output logic [22:0] mem_addr,
  output logic        mem_clk,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_adv_n,
  output logic [1:0]  mem_be,
  output logic        mem_cre,
  inout  wire  [15:0] mem_data,
  input  logic        mem_wait
);

  localparam logic [15:0] INIT_LAST = 16'(init_cycles - 1);
  localparam logic [15:0] ACC_LAST  = 16'(t_acc - 1);
  localparam logic [22:0] WORD_LAST = 23'(n_words - 1);

  typedef enum logic [3:0] {
    INIT,
    WR_ADDR,
    WR_PULSE,
    WR_REC,
    RD_ADDR,
    RD_PULSE,
    RD_REC,
`ifdef PSRAM_BYTE_LANE_TEST_EN
    BW_ADDR,
    BW_PULSE,
    BW_REC,
    BR_ADDR,
    BR_PULSE,
    BR_REC,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [22:0] idx;
  logic [22:0] nidx;
  logic        last;
  logic [5:0]  err;
  logic [5:0]  err_inc;
  logic [15:0] wdata;
  logic [15:0] rd_exp;
  logic        data_oe;
  logic        mismatch;
  logic        unused_ok;

  function automatic logic [15:0] pattern(input logic [7:0] a);
    return {~a, a};
  endfunction

  assign last      = (idx == WORD_LAST);
  assign nidx      = last ? '0 : idx + 23'd1;
  assign err_inc   = (err == 6'h3f) ? err : err + 6'd1;
  assign mismatch  = (mem_data != rd_exp);
  assign mem_data  = data_oe ? wdata : 16'hzzzz;
  assign mem_clk   = 1'b0;
  assign mem_adv_n = 1'b0;
  assign mem_cre   = 1'b0;
  assign unused_ok = mem_wait ^ (clk_freq == 0);

  // Access sequencer: power-up wait, write sweep, read sweep, status.
  always_ff @(posedge clk or posedge btns) begin
    if (btns) begin
      state    <= INIT;
      cnt      <= '0;
      idx      <= '0;
      err      <= '0;
      leds     <= '0;
      mem_addr <= '0;
      mem_be   <= 2'b11;
      mem_ce_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      data_oe  <= 1'b0;
      wdata    <= '0;
      rd_exp   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (cnt == INIT_LAST) begin
            cnt      <= '0;
            mem_addr <= idx;
            mem_be   <= 2'b00;
            mem_ce_n <= 1'b0;
            wdata    <= pattern(idx[7:0]);
            data_oe  <= 1'b1;
            state    <= WR_ADDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_ADDR: begin
          mem_we_n <= 1'b0;
          state    <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == ACC_LAST) begin
            cnt      <= '0;
            mem_we_n <= 1'b1;
            mem_ce_n <= 1'b1;
            mem_be   <= 2'b11;
            data_oe  <= 1'b0;
            state    <= WR_REC;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_REC: begin
          idx      <= nidx;
          mem_addr <= nidx;
          mem_be   <= 2'b00;
          mem_ce_n <= 1'b0;
          if (last) begin
            rd_exp <= pattern(nidx[7:0]);
            state  <= RD_ADDR;
          end else begin
            wdata   <= pattern(nidx[7:0]);
            data_oe <= 1'b1;
            state   <= WR_ADDR;
          end
        end
        RD_ADDR: begin
          mem_oe_n <= 1'b0;
          state    <= RD_PULSE;
        end
        RD_PULSE: begin
          if (cnt == ACC_LAST) begin
            cnt      <= '0;
            mem_oe_n <= 1'b1;
            mem_ce_n <= 1'b1;
            mem_be   <= 2'b11;
            state    <= RD_REC;
            if (mismatch) begin
              err  <= err_inc;
              leds <= {2'b00, err_inc};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RD_REC: begin
          idx <= nidx;
          if (last) begin
`ifdef PSRAM_BYTE_LANE_TEST_EN
            mem_addr <= '0;
            mem_be   <= 2'b01;
            mem_ce_n <= 1'b0;
            wdata    <= 16'hA500;
            data_oe  <= 1'b1;
            state    <= BW_ADDR;
`else
            leds  <= {1'b1, err == 6'd0, err};
            state <= DONE;
`endif
          end else begin
            mem_addr <= nidx;
            mem_be   <= 2'b00;
            mem_ce_n <= 1'b0;
            rd_exp   <= pattern(nidx[7:0]);
            state    <= RD_ADDR;
          end
        end
`ifdef PSRAM_BYTE_LANE_TEST_EN
        BW_ADDR: begin
          mem_we_n <= 1'b0;
          state    <= BW_PULSE;
        end
        BW_PULSE: begin
          if (cnt == ACC_LAST) begin
            cnt      <= '0;
            mem_we_n <= 1'b1;
            mem_ce_n <= 1'b1;
            mem_be   <= 2'b11;
            data_oe  <= 1'b0;
            state    <= BW_REC;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BW_REC: begin
          mem_addr <= '0;
          mem_be   <= 2'b00;
          mem_ce_n <= 1'b0;
          rd_exp   <= 16'hA500;
          state    <= BR_ADDR;
        end
        BR_ADDR: begin
          mem_oe_n <= 1'b0;
          state    <= BR_PULSE;
        end
        BR_PULSE: begin
          if (cnt == ACC_LAST) begin
            cnt      <= '0;
            mem_oe_n <= 1'b1;
            mem_ce_n <= 1'b1;
            mem_be   <= 2'b11;
            state    <= BR_REC;
            if (mismatch) begin
              err  <= err_inc;
              leds <= {2'b00, err_inc};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BR_REC: begin
          leds  <= {1'b1, err == 6'd0, err};
          state <= DONE;
        end
`endif
        DONE: state <= DONE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_system.sv
// tb_psram_system: directed bench for psram_system
// with a small behavioural async PSRAM model.
`timescale 1ns/1ps
module tb_psram_system;

`ifdef PSRAM_BYTE_LANE_TEST_EN
  localparam int RUN_CYC  = 9040;
  localparam int BYTE_EXP = 6;
`else
  localparam int RUN_CYC  = 9024;
  localparam int BYTE_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        btns;
  logic [7:0]  leds;
  logic [22:0] mem_addr;
  logic        mem_clk;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_adv_n;
  logic [1:0]  mem_be;
  logic        mem_cre;
  wire  [15:0] mem_data;
  logic        mem_wait = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:63];
  logic        quiet = 1'b0;
  logic        stuck3 = 1'b0;
  logic        invert = 1'b0;
  logic        clear_mem = 1'b0;
  logic [15:0] rdata;
  logic        model_drive;
  int          const_bad = 0;
  int          strobe_bad = 0;
  int          byte_cycles = 0;

  always #6.25 clk = ~clk;

  psram_system dut (
    .clk       (clk),
    .btns      (btns),
    .leds      (leds),
    .mem_addr  (mem_addr),
    .mem_clk   (mem_clk),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .mem_adv_n (mem_adv_n),
    .mem_be    (mem_be),
    .mem_cre   (mem_cre),
    .mem_data  (mem_data),
    .mem_wait  (mem_wait)
  );

  always_comb begin
    rdata = mem[mem_addr[5:0]];
    if (stuck3) rdata[3] = 1'b0;
    if (invert) rdata = ~rdata;
  end

  assign model_drive = !mem_ce_n && !mem_oe_n && mem_we_n && !quiet;
  assign mem_data = model_drive ? rdata : 16'hzzzz;

  // Memory array write port and pin monitors.
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h5A5A;
    end else if (!mem_ce_n && !mem_we_n) begin
      if (!mem_be[0]) mem[mem_addr[5:0]][7:0] <= mem_data[7:0];
      if (!mem_be[1]) mem[mem_addr[5:0]][15:8] <= mem_data[15:8];
    end
    if (mem_clk || mem_adv_n || mem_cre) const_bad <= const_bad + 1;
    if (!mem_oe_n && !mem_we_n) strobe_bad <= strobe_bad + 1;
    if (!mem_ce_n && !mem_we_n && mem_be == 2'b01 &&
        mem_addr == 23'd0 && mem_data[15:8] == 8'hA5)
      byte_cycles <= byte_cycles + 1;
  end

  task automatic start_run;
    btns = 1'b1;
    clear_mem = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #4;
    clear_mem = 1'b0;
    btns = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < RUN_CYC + 100 && leds[7] !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    btns = 1'b1;
    clear_mem = 1'b1;
    #10;
    checks++;
    if (leds !== 8'h00) begin
      errors++;
      $display("FAIL rst_leds got %h want 00", leds);
    end
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111) begin
      errors++;
      $display("FAIL rst_strobes got %b want 111",
               {mem_ce_n, mem_oe_n, mem_we_n});
    end
    checks++;
    if (mem_be !== 2'b11) begin
      errors++;
      $display("FAIL rst_be got %b want 11", mem_be);
    end
    checks++;
    if (mem_addr !== 23'd0) begin
      errors++;
      $display("FAIL rst_addr got %h want 0", mem_addr);
    end
    checks++;
    if (mem_data !== 16'hzzzz && mem_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_bus got %h want released", mem_data);
    end
    checks++;
    if ({mem_clk, mem_adv_n, mem_cre} !== 3'b000) begin
      errors++;
      $display("FAIL rst_const got %b want 000",
               {mem_clk, mem_adv_n, mem_cre});
    end
    clear_mem = 1'b0;
    btns = 1'b0;
  endtask

  task automatic test_init_timing;
    int n = 0;
    while (n < 8100 && mem_ce_n !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 8000) begin
      errors++;
      $display("FAIL init_len got %0d want 8000", n);
    end
    checks++;
    if (leds !== 8'h00) begin
      errors++;
      $display("FAIL busy_leds got %h want 00", leds);
    end
  endtask

  task automatic test_write_waveform;
    int ce_cnt = 0;
    int we_cnt = 0;
    int bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (mem_ce_n === 1'b0) ce_cnt++;
      if (mem_we_n === 1'b0) we_cnt++;
      if (mem_ce_n === 1'b0 && (mem_addr !== 23'd0 ||
          mem_be !== 2'b00 || mem_data !== 16'hFF00))
        bad++;
    end
    checks++;
    if (ce_cnt !== 7) begin
      errors++;
      $display("FAIL wr_ce_len got %0d want 7", ce_cnt);
    end
    checks++;
    if (we_cnt !== 6) begin
      errors++;
      $display("FAIL wr_we_len got %0d want 6", we_cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wr_stable got %0d bad cycles want 0", bad);
    end
    checks++;
    if (mem_data !== 16'hzzzz && mem_data !== 16'h0000) begin
      errors++;
      $display("FAIL wr_rec_bus got %h want released", mem_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_addr !== 23'd1 || mem_data !== 16'hFE01 ||
        mem_ce_n !== 1'b0) begin
      errors++;
      $display("FAIL wr2_addr got %h/%h want 000001/FE01",
               mem_addr, mem_data);
    end
  endtask

  task automatic test_read_waveform;
    int n = 0;
    int oe_cnt = 0;
    int bad = 0;
    while (n < 700 && mem_oe_n !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    while (mem_oe_n === 1'b0 && oe_cnt < 10) begin
      oe_cnt++;
      if (mem_addr !== 23'd0 || mem_we_n !== 1'b1 ||
          mem_ce_n !== 1'b0 || mem_data !== 16'hFF00)
        bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (oe_cnt !== 6) begin
      errors++;
      $display("FAIL rd_oe_len got %0d want 6", oe_cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rd_stable got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_fault_free_done;
    while ($realtime < 160010.0) @(posedge clk);
    #1;
    checks++;
    if (leds !== 8'hC0) begin
      errors++;
      $display("FAIL pass_leds got %h want C0", leds);
    end
    checks++;
    if (mem_ce_n !== 1'b1) begin
      errors++;
      $display("FAIL done_idle got %b want 1", mem_ce_n);
    end
    checks++;
    if (const_bad !== 0) begin
      errors++;
      $display("FAIL const_pins got %0d want 0", const_bad);
    end
    checks++;
    if (strobe_bad !== 0) begin
      errors++;
      $display("FAIL oe_we_overlap got %0d want 0", strobe_bad);
    end
    checks++;
    if (byte_cycles !== BYTE_EXP) begin
      errors++;
      $display("FAIL byte_lane got %0d want %0d",
               byte_cycles, BYTE_EXP);
    end
  endtask

  task automatic test_stuck_bit;
    int n;
    start_run();
    stuck3 = 1'b1;
    wait_done(n);
    checks++;
    if (n !== RUN_CYC) begin
      errors++;
      $display("FAIL runtime got %0d want %0d", n, RUN_CYC);
    end
    checks++;
    if (leds !== 8'hA0) begin
      errors++;
      $display("FAIL stuck_leds got %h want A0", leds);
    end
    stuck3 = 1'b0;
  endtask

  task automatic test_saturation;
    int n;
    start_run();
    invert = 1'b1;
    wait_done(n);
    checks++;
    if (leds !== 8'hBF) begin
      errors++;
      $display("FAIL sat_leds got %h want BF", leds);
    end
    invert = 1'b0;
  endtask

  task automatic test_mid_reset;
    int n;
    start_run();
    repeat (8040) @(posedge clk);
    #3;
    btns = 1'b1;
    #1;
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111 ||
        mem_be !== 2'b11) begin
      errors++;
      $display("FAIL mid_strobes got %b/%b want 111/11",
               {mem_ce_n, mem_oe_n, mem_we_n}, mem_be);
    end
    checks++;
    if (mem_data !== 16'hzzzz && mem_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_bus got %h want released", mem_data);
    end
    checks++;
    if (mem_addr !== 23'd0 || leds !== 8'h00) begin
      errors++;
      $display("FAIL mid_addr_leds got %h/%h want 0/00",
               mem_addr, leds);
    end
    #19;
    btns = 1'b0;
    wait_done(n);
    checks++;
    if (n !== RUN_CYC) begin
      errors++;
      $display("FAIL mid_runtime got %0d want %0d", n, RUN_CYC);
    end
    checks++;
    if (leds !== 8'hC0) begin
      errors++;
      $display("FAIL mid_leds got %h want C0", leds);
    end
  endtask

  task automatic test_read_hiz;
    int n = 0;
    int hiz = 0;
    start_run();
    quiet = 1'b1;
    while (n < 8700 && mem_oe_n !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      if (mem_oe_n === 1'b0 &&
          (mem_data === 16'hzzzz || mem_data === 16'h0000))
        hiz++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hiz !== 6) begin
      errors++;
      $display("FAIL rd_hiz got %0d want 6", hiz);
    end
    quiet = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_write_waveform();
    test_read_waveform();
    test_fault_free_done();
    test_stuck_bit();
    test_saturation();
    test_mid_reset();
    test_read_hiz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
